// File: rtl/pc_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_predict_unit
//  Purpose  : IF-stage program counter with trap/redirect priority, stall
//             hold and next-PC prediction from a direct-mapped BTB of 2-bit
//             saturating counters trained by the EX stage.
//  Ports    : clk, reset (sync, active-high)
//             stall                          - hold the fetch PC
//             trap_valid / trap_vector       - highest-priority PC load
//             redirect_valid/redirect_target - EX-stage correction
//             upd_valid/upd_pc/upd_taken/upd_target - BTB training
//             pc                             - current fetch PC
//             pred_taken / pred_target       - combinational BTB lookup on pc
//  Revision : 1.0 - initial release
// ============================================================================
module pc_predict_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    localparam int              IDX_W     = $clog2(BTB_ENTRIES);
    localparam int              TAG_W     = XLEN - 2 - IDX_W;
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    // BTB storage: valid/counter are reset, tag/target are not.
    logic [BTB_ENTRIES-1:0] r_valid;
    logic [1:0]             r_ctr [BTB_ENTRIES];
    logic [TAG_W-1:0]       r_tag [BTB_ENTRIES];
    logic [XLEN-1:0]        r_tgt [BTB_ENTRIES];

    logic [XLEN-1:0]        r_pc;

    // ------------------------------------------------------------------
    // Lookup on the current fetch PC
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic             w_pred_taken;
    logic [XLEN-1:0]  w_pred_target;

    assign w_lk_idx      = r_pc[IDX_W+1:2];
    assign w_lk_tag      = r_pc[XLEN-1:IDX_W+2];
    assign w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    assign w_pred_target = w_pred_taken ? r_tgt[w_lk_idx] : '0;

    assign pc          = r_pc;
    assign pred_taken  = w_pred_taken;
    assign pred_target = w_pred_target;

    // ------------------------------------------------------------------
    // Next-PC selection; trap and redirect take precedence over stall.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_next_pc;

    always_comb begin
        w_next_pc = r_pc + c_PC_STEP;
        if (trap_valid) begin
            w_next_pc = {trap_vector[XLEN-1:2], 2'b00};
        end else if (redirect_valid) begin
            w_next_pc = {redirect_target[XLEN-1:2], 2'b00};
        end else if (stall) begin
            w_next_pc = r_pc;
        end else if (w_pred_taken) begin
            w_next_pc = w_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= {RESET_VECTOR[XLEN-1:2], 2'b00};
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // ------------------------------------------------------------------
    // BTB training. Writes land at the clock edge, so a lookup on the same
    // index in the same cycle still sees the old entry.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [1:0]       w_up_ctr;
    logic [XLEN-1:0]  w_up_tgt;

    assign w_up_idx = upd_pc[IDX_W+1:2];
    assign w_up_tag = upd_pc[XLEN-1:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr = r_ctr[w_up_idx];
    assign w_up_tgt = {upd_target[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                if (upd_taken) begin
                    if (w_up_ctr != 2'b11) begin
                        r_ctr[w_up_idx] <= w_up_ctr + 2'b01;
                    end
                end else if (w_up_ctr != 2'b00) begin
                    r_ctr[w_up_idx] <= w_up_ctr - 2'b01;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliased into this slot.
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= 2'b10;
            end
        end
    end

    // Any taken update either hits (tag unchanged) or allocates, so the
    // tag and target can be written unconditionally on a taken update.
    always_ff @(posedge clk) begin
        if (!reset && upd_valid && upd_taken) begin
            r_tag[w_up_idx] <= w_up_tag;
            r_tgt[w_up_idx] <= w_up_tgt;
        end
    end

    // Address bits [1:0] carry no information for a word-aligned fetch.
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{trap_vector[1:0], redirect_target[1:0],
                             upd_pc[1:0], upd_target[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_pc_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_predict_unit
//  Purpose  : Self-checking bench for pc_predict_unit: directed scenarios with
//             fixed expected PCs plus randomized traffic compared against a
//             behavioural next-PC / BTB model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_predict_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    int checks = 0;
    int errors = 0;

    pc_predict_unit #(
        .XLEN        (32),
        .RESET_VECTOR(32'h100),
        .BTB_ENTRIES (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: 16-entry table, full-PC tag (pc >> 6), integer counter
    // ------------------------------------------------------------------
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];
    logic [31:0] m_pc;

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) % 32'd16);
    endfunction

    function automatic bit m_pt();
        int i;
        i = m_idx(m_pc);
        return m_valid[i] && (m_tag[i] == (m_pc >> 6)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt();
        return m_pt() ? m_tgt[m_idx(m_pc)] : 32'h0;
    endfunction

    // Advance one clock: model computes from pre-edge state and inputs.
    task automatic tick();
        logic [31:0] npc;
        bit          c_rst, c_up, c_tk;
        logic [31:0] c_upc, c_utgt;
        int          ui;
        if (reset)               npc = 32'h100;
        else if (trap_valid)     npc = trap_vector & ~32'h3;
        else if (redirect_valid) npc = redirect_target & ~32'h3;
        else if (stall)          npc = m_pc;
        else if (m_pt())         npc = m_ptgt();
        else                     npc = m_pc + 32'd4;
        c_rst  = reset;
        c_up   = upd_valid;
        c_tk   = upd_taken;
        c_upc  = upd_pc;
        c_utgt = upd_target & ~32'h3;
        @(posedge clk);
        #1;
        m_pc = npc;
        if (c_rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
        end else if (c_up) begin
            ui = m_idx(c_upc);
            if (m_valid[ui] && m_tag[ui] == (c_upc >> 6)) begin
                if (c_tk) begin
                    m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
                    m_tgt[ui] = c_utgt;
                end else begin
                    m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                end
            end else if (c_tk) begin
                m_valid[ui] = 1;
                m_tag[ui]   = c_upc >> 6;
                m_tgt[ui]   = c_utgt;
                m_ctr[ui]   = 2;
            end
        end
    endtask

    task automatic idle_inputs();
        stall = 0; trap_valid = 0; redirect_valid = 0; upd_valid = 0;
        upd_taken = 0; trap_vector = 0; redirect_target = 0;
        upd_pc = 0; upd_target = 0;
    endtask

    task automatic train(input logic [31:0] a, input bit tk, input logic [31:0] t);
        upd_valid = 1; upd_pc = a; upd_taken = tk; upd_target = t;
        tick();
        upd_valid = 0;
    endtask

    task automatic jump(input logic [31:0] t);
        redirect_valid = 1; redirect_target = t;
        tick();
        redirect_valid = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        checks++;
        if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc actual=%h required=%h", pc, 32'h100); end
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
            errors++; $display("FAIL reset_pred actual=%b/%h required=0/0", pred_taken, pred_target);
        end
        reset = 0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (pc !== 32'h100 + 32'(4 * k) || pred_taken !== 1'b0) begin
                errors++; $display("FAIL seq_pc%0d actual=%h/%b required=%h/0", k, pc, pred_taken, 32'h100 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall_redirect();
        stall = 1;
        tick();
        checks++;
        if (pc !== 32'h108) begin errors++; $display("FAIL stall_hold actual=%h required=%h", pc, 32'h108); end
        redirect_valid = 1; redirect_target = 32'h200;
        tick();
        redirect_valid = 0;
        checks++;
        if (pc !== 32'h200) begin errors++; $display("FAIL redirect_over_stall actual=%h required=%h", pc, 32'h200); end
        tick();
        checks++;
        if (pc !== 32'h200) begin errors++; $display("FAIL stall_hold2 actual=%h required=%h", pc, 32'h200); end
        stall = 0;
        tick();
        checks++;
        if (pc !== 32'h204) begin errors++; $display("FAIL stall_release actual=%h required=%h", pc, 32'h204); end
        stall = 1; trap_valid = 1; trap_vector = 32'h80;
        redirect_valid = 1; redirect_target = 32'h300;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h80) begin errors++; $display("FAIL trap_priority actual=%h required=%h", pc, 32'h80); end
    endtask

    task automatic test_train_predict();
        upd_valid = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 32'h400;
        redirect_valid = 1; redirect_target = 32'h40;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h40 || pred_taken !== 1'b1 || pred_target !== 32'h400) begin
            errors++; $display("FAIL alloc_predict actual=%h/%b/%h required=40/1/400", pc, pred_taken, pred_target);
        end
        tick();
        checks++;
        if (pc !== 32'h400) begin errors++; $display("FAIL pred_follow actual=%h required=%h", pc, 32'h400); end
        train(32'h40, 0, 32'h0);
        train(32'h40, 0, 32'h0);
        jump(32'h40);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
            errors++; $display("FAIL weakened_pred actual=%b/%h required=0/0", pred_taken, pred_target);
        end
        tick();
        checks++;
        if (pc !== 32'h44) begin errors++; $display("FAIL fallthrough actual=%h required=%h", pc, 32'h44); end
    endtask

    task automatic test_saturation();
        // counter starts at 00; five taken updates must stick at 11
        for (int k = 0; k < 5; k++) train(32'h40, 1, (k == 4) ? 32'h500 : 32'h400);
        train(32'h40, 0, 32'h0);
        jump(32'h40);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h500) begin
            errors++; $display("FAIL saturate_pred actual=%b/%h required=1/500", pred_taken, pred_target);
        end
        tick();
        checks++;
        if (pc !== 32'h500) begin errors++; $display("FAIL saturate_follow actual=%h required=%h", pc, 32'h500); end
    endtask

    task automatic test_alias();
        train(32'h80, 1, 32'h800);
        jump(32'h40);
        checks++;
        if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evicted actual=%b required=0", pred_taken); end
        tick();
        checks++;
        if (pc !== 32'h44) begin errors++; $display("FAIL alias_fallthrough actual=%h required=%h", pc, 32'h44); end
        jump(32'h80);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h800) begin
            errors++; $display("FAIL alias_hit actual=%b/%h required=1/800", pred_taken, pred_target);
        end
    endtask

    task automatic test_boundaries();
        jump(32'hFFFF_FFFC);
        tick();
        checks++;
        if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap actual=%h required=0", pc); end
        jump(32'h203);
        checks++;
        if (pc !== 32'h200) begin errors++; $display("FAIL redirect_align actual=%h required=%h", pc, 32'h200); end
        trap_valid = 1; trap_vector = 32'h87;
        tick();
        trap_valid = 0;
        checks++;
        if (pc !== 32'h84) begin errors++; $display("FAIL trap_align actual=%h required=%h", pc, 32'h84); end
        // same-cycle update on the looked-up index
        jump(32'h600);
        stall = 1;
        upd_valid = 1; upd_pc = 32'h600; upd_taken = 1; upd_target = 32'h703;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_old actual=%b required=0", pred_taken); end
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h600 || pred_taken !== 1'b1 || pred_target !== 32'h700) begin
            errors++; $display("FAIL same_cycle_new actual=%h/%b/%h required=600/1/700", pc, pred_taken, pred_target);
        end
        tick();
        checks++;
        if (pc !== 32'h700) begin errors++; $display("FAIL same_cycle_follow actual=%h required=%h", pc, 32'h700); end
        // reset beats a simultaneous update and clears the table
        reset = 1; upd_valid = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 32'h900;
        tick();
        idle_inputs();
        reset = 0;
        jump(32'h40);
        checks++;
        if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_vs_update actual=%b required=0", pred_taken); end
        jump(32'h600);
        checks++;
        if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_clears actual=%b required=0", pred_taken); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            trap_valid      = ($urandom_range(0, 31) == 0);
            trap_vector     = $urandom_range(0, 255) << 2 | $urandom_range(0, 3);
            redirect_valid  = ($urandom_range(0, 9) == 0);
            redirect_target = $urandom_range(0, 255) << 2 | $urandom_range(0, 3);
            stall           = ($urandom_range(0, 4) == 0);
            upd_valid       = ($urandom_range(0, 9) < 4);
            upd_pc          = $urandom_range(0, 255) << 2;
            upd_taken       = ($urandom_range(0, 2) != 0);
            upd_target      = $urandom_range(0, 255) << 2 | $urandom_range(0, 3);
            tick();
            checks++;
            if (pc !== m_pc || pred_taken !== m_pt() || pred_target !== m_ptgt()) begin
                errors++;
                $display("FAIL random_%0d actual=%h/%b/%h required=%h/%b/%h",
                         n, pc, pred_taken, pred_target, m_pc, m_pt(), m_ptgt());
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_stall_redirect();
        test_train_predict();
        test_saturation();
        test_alias();
        test_boundaries();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
